// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
package uart_pkg;

  localparam int UART_BYTE_W            = 8;
  localparam int UART_TXQ_DEPTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    sIdle,
    sSend,
    sWaitDone
  } tTxqState;

endpackage

// File: rtl/byte_fifo.sv
// Byte FIFO: array storage, wrapping pointers, ADDR_W+1 bit occupancy count.
// The read register doubles as the UART data holding register.
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_TXQ_DEPTH_DEFAULT,
  parameter int ADDR_W = 4
) (
  input  logic                   ipClk,
  input  logic                   nReset,
  input  logic [UART_BYTE_W-1:0] wr_data,
  input  logic                   wr_valid,
  input  logic                   rd_en,
  output logic [UART_BYTE_W-1:0] rd_data,
  output logic [ADDR_W:0]        count,
  output logic                   empty,
  output logic                   full
);

  logic [UART_BYTE_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]        count_q, count_d;
  logic [UART_BYTE_W-1:0] rd_data_q, rd_data_d;
  logic                   push, pop;

  // Flags come from the registered count only, so nothing here depends on wr_valid.
  assign full    = (count_q == (ADDR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = rd_data_q;

  always_comb begin
    push      = wr_valid && !full;
    pop       = rd_en && !empty;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
      rd_data_d = mem_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_W+1)'(1);
      2'b01:   count_d = count_q - (ADDR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge ipClk) begin
    if (nReset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage is not reset so it can map onto RAM primitives.
  always_ff @(posedge ipClk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue that feeds the UART transmitter over its send/busy handshake.
// Define UART_TXQ_TIMEOUT_EN to add the busy-rise timeout and sticky opTimeout.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH  = UART_TXQ_DEPTH_DEFAULT,
  parameter int ADDR_W = 4
`ifdef UART_TXQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 4096
`endif
) (
  input  logic                   ipClk,
  input  logic                   nReset,
  input  logic [UART_BYTE_W-1:0] ipData,
  input  logic                   ipValid,
  output logic                   opReady,
  output logic [ADDR_W:0]        opCount,
  output logic                   opEmpty,
  output logic                   opFull,
  output logic [UART_BYTE_W-1:0] opTxData,
  output logic                   opTxSend,
  input  logic                   ipTxBusy
`ifdef UART_TXQ_TIMEOUT_EN
  ,
  output logic                   opTimeout
`endif
);

  tTxqState state_q, state_d;
  logic     send_q, send_d;
  logic     pop;
  logic     fifo_empty, fifo_full;

  byte_fifo #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .ipClk    (ipClk),
    .nReset   (nReset),
    .wr_data  (ipData),
    .wr_valid (ipValid),
    .rd_en    (pop),
    .rd_data  (opTxData),
    .count    (opCount),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign opEmpty  = fifo_empty;
  assign opFull   = fifo_full;
  assign opReady  = ~fifo_full;
  assign opTxSend = send_q;

`ifdef UART_TXQ_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             timeout_q, timeout_d;
  assign opTimeout = timeout_q;
`endif

  always_comb begin
    state_d = state_q;
    send_d  = send_q;
    pop     = 1'b0;
`ifdef UART_TXQ_TIMEOUT_EN
    timeout_d = timeout_q;
    timer_d   = (state_q == sSend) ? timer_q + TMR_W'(1) : '0;
`endif
    case (state_q)
      sIdle: begin
        if (!fifo_empty && !ipTxBusy) begin
          pop     = 1'b1;
          send_d  = 1'b1;
          state_d = sSend;
        end
      end
      sSend: begin
        if (ipTxBusy) begin
          send_d  = 1'b0;
          state_d = sWaitDone;
        end
`ifdef UART_TXQ_TIMEOUT_EN
        // UART never acknowledged: drop this byte and move on.
        else if (timer_q == TMR_W'(TIMEOUT_CYCLES - 1)) begin
          send_d    = 1'b0;
          state_d   = sIdle;
          timeout_d = 1'b1;
        end
`endif
      end
      sWaitDone: begin
        if (!ipTxBusy) begin
          state_d = sIdle;
        end
      end
      default: begin
        send_d  = 1'b0;
        state_d = sIdle;
      end
    endcase
  end

  always_ff @(posedge ipClk) begin
    if (nReset) begin
      state_q <= sIdle;
      send_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      send_q  <= send_d;
    end
  end

`ifdef UART_TXQ_TIMEOUT_EN
  always_ff @(posedge ipClk) begin
    if (nReset) begin
      timer_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      timer_q   <= timer_d;
      timeout_q <= timeout_d;
    end
  end
`endif

endmodule
